// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq - staged reset sequencer
//
// Sits downstream of the clock/reset generator. Once the PLL lock (clk_ok)
// has been synchronised and seen high, per-subsystem resets are released
// one at a time, in index order. Consecutive releases are STAGE_DLY cycles
// apart. A stage whose ACK_MASK bit is set must raise its ack bit before
// the next stage proceeds. If that ack does not arrive within ACK_TIMEOUT
// cycles, the sequencer enters a sticky fault state with every stage held
// in reset. Losing lock before a fault puts every stage back in reset and
// restarts the sequence from stage 0.
//
// Ports
//   clk          system clock (only clock domain)
//   rst          synchronous, active-high reset
//   clk_ok       PLL lock, asynchronous; 2-flop synchronised internally
//   ack          per-stage init-done acknowledge, synchronous to clk
//   stage_rst    per-stage reset, active-high, registered
//   all_ready    every stage released, registered
//   fault        acknowledge timeout, sticky until rst
//   fault_stage  index of the stage whose acknowledge timed out
// ---------------------------------------------------------------------------
module rst_seq #(
    parameter int unsigned            NUM_STAGES  = 4,
    parameter int unsigned            STAGE_DLY   = 16,
    parameter logic [NUM_STAGES-1:0]  ACK_MASK    = 4'b0010,
    parameter int unsigned            ACK_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_ok,
    input  logic [NUM_STAGES-1:0] ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  fault,
    output logic [2:0]            fault_stage
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DLY,
        S_WAIT_ACK,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [2:0]  LAST_K = 3'(NUM_STAGES - 1);
    localparam logic [23:0] DLY_END = 24'(STAGE_DLY - 1);
    localparam logic [23:0] TO_END  = 24'(ACK_TIMEOUT - 1);

    // Lock synchroniser; clk_ok_s is the second flop.
    logic                  sync1_q;
    logic                  clk_ok_s_q;

    state_t                state_q;
    logic [2:0]            k_q;
    logic [23:0]           cnt_q;
    logic [NUM_STAGES-1:0] stage_rst_q;
    logic                  all_ready_q;
    logic                  fault_q;
    logic [2:0]            fault_stage_q;

    // One-hot decode of the current stage index. Working through this
    // vector rather than indexing with k_q keeps every select in range
    // whatever NUM_STAGES is.
    logic [NUM_STAGES-1:0] stage_sel;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
        localparam logic [2:0] IDX = 3'(gi);
        assign stage_sel[gi] = (k_q == IDX);
    end

    logic        dly_done;
    logic        to_done;
    logic        ack_hit;
    logic        need_ack;
    logic        is_last;
    logic [23:0] cnt_d;

    always_comb begin
        dly_done = (cnt_q == DLY_END);
        to_done  = (cnt_q == TO_END);
        ack_hit  = |(ack & stage_sel);       // only the current stage's ack counts
        need_ack = |(ACK_MASK & stage_sel);
        is_last  = (k_q == LAST_K);
        cnt_d    = cnt_q + 24'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            clk_ok_s_q    <= 1'b0;
            state_q       <= S_IDLE;
            k_q           <= 3'd0;
            cnt_q         <= 24'd0;
            stage_rst_q   <= '1;
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= 3'd0;
        end else begin
            sync1_q    <= clk_ok;
            clk_ok_s_q <= sync1_q;

            case (state_q)
                S_IDLE: begin
                    stage_rst_q <= '1;
                    all_ready_q <= 1'b0;
                    k_q         <= 3'd0;
                    cnt_q       <= 24'd0;
                    if (clk_ok_s_q) begin
                        state_q <= S_WAIT_DLY;
                    end
                end

                // Fault holds everything; lock and ack no longer matter.
                S_FAULT: begin
                    stage_rst_q <= '1;
                    all_ready_q <= 1'b0;
                end

                default: begin
                    if (!clk_ok_s_q) begin
                        // Lock lost: drop back and restart from stage 0.
                        state_q     <= S_IDLE;
                        stage_rst_q <= '1;
                        all_ready_q <= 1'b0;
                        k_q         <= 3'd0;
                        cnt_q       <= 24'd0;
                    end else begin
                        case (state_q)
                            S_WAIT_DLY: begin
                                if (dly_done) begin
                                    stage_rst_q <= stage_rst_q & ~stage_sel;
                                    cnt_q       <= 24'd0;
                                    if (need_ack) begin
                                        state_q <= S_WAIT_ACK;
                                    end else if (is_last) begin
                                        // Last bit falls and ready rises together.
                                        state_q     <= S_RUN;
                                        all_ready_q <= 1'b1;
                                    end else begin
                                        k_q <= k_q + 3'd1;
                                    end
                                end else begin
                                    cnt_q <= cnt_d;
                                end
                            end

                            S_WAIT_ACK: begin
                                // Ack is checked before timeout, so an ack
                                // on the final count still wins.
                                if (ack_hit) begin
                                    cnt_q <= 24'd0;
                                    if (is_last) begin
                                        state_q     <= S_RUN;
                                        all_ready_q <= 1'b1;
                                    end else begin
                                        state_q <= S_WAIT_DLY;
                                        k_q     <= k_q + 3'd1;
                                    end
                                end else if (to_done) begin
                                    state_q       <= S_FAULT;
                                    cnt_q         <= 24'd0;
                                    fault_q       <= 1'b1;
                                    fault_stage_q <= k_q;
                                    stage_rst_q   <= '1;
                                    all_ready_q   <= 1'b0;
                                end else begin
                                    cnt_q <= cnt_d;
                                end
                            end

                            default: begin
                                // S_RUN: hold until rst or lock loss.
                                all_ready_q <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign stage_rst   = stage_rst_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq - directed bench for rst_seq
//
// Two instances share clk, rst and clk_ok:
//   dut_a : STAGE_DLY=4, ACK_MASK=0000 (pure delay sequencing)
//   dut_b : STAGE_DLY=4, ACK_MASK=0010, ACK_TIMEOUT=20
// Edge numbers in the comments count rising edges after rst was dropped.
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       clk_ok;
    logic [3:0] ack_a;
    logic [3:0] ack_b;

    logic [3:0] stage_rst_a;
    logic       all_ready_a;
    logic       fault_a;
    logic [2:0] fault_stage_a;

    logic [3:0] stage_rst_b;
    logic       all_ready_b;
    logic       fault_b;
    logic [2:0] fault_stage_b;

    int total;
    int bad;

    rst_seq #(
        .NUM_STAGES  (4),
        .STAGE_DLY   (4),
        .ACK_MASK    (4'b0000),
        .ACK_TIMEOUT (20)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .clk_ok      (clk_ok),
        .ack         (ack_a),
        .stage_rst   (stage_rst_a),
        .all_ready   (all_ready_a),
        .fault       (fault_a),
        .fault_stage (fault_stage_a)
    );

    rst_seq #(
        .NUM_STAGES  (4),
        .STAGE_DLY   (4),
        .ACK_MASK    (4'b0010),
        .ACK_TIMEOUT (20)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .clk_ok      (clk_ok),
        .ack         (ack_b),
        .stage_rst   (stage_rst_b),
        .all_ready   (all_ready_b),
        .fault       (fault_b),
        .fault_stage (fault_stage_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        clk_ok = 1'b1;
        ack_a  = 4'b0000;
        ack_b  = 4'b0000;

        // ---------------- reset state ----------------
        steps(3);
        chk("rst_stage_a",   32'(stage_rst_a),   32'hF);
        chk("rst_ready_a",   32'(all_ready_a),   32'h0);
        chk("rst_fault_a",   32'(fault_a),       32'h0);
        chk("rst_fstage_a",  32'(fault_stage_a), 32'h0);
        chk("rst_stage_b",   32'(stage_rst_b),   32'hF);
        chk("rst_fault_b",   32'(fault_b),       32'h0);

        // ---------------- T1 (dut_a) + T2 (dut_b) ----------------
        rst = 1'b0;
        steps(6);   // E6: one edge before first release
        chk("t1_e6_a",       32'(stage_rst_a),   32'hF);
        chk("t2_e6_b",       32'(stage_rst_b),   32'hF);
        steps(1);   // E7
        chk("t1_e7_a",       32'(stage_rst_a),   32'hE);
        chk("t2_e7_b",       32'(stage_rst_b),   32'hE);
        steps(3);   // E10
        chk("t1_e10_a",      32'(stage_rst_a),   32'hE);
        steps(1);   // E11
        chk("t1_e11_a",      32'(stage_rst_a),   32'hC);
        chk("t2_e11_b",      32'(stage_rst_b),   32'hC);
        steps(4);   // E15
        chk("t1_e15_a",      32'(stage_rst_a),   32'h8);
        chk("t2_e15_b",      32'(stage_rst_b),   32'hC);
        steps(3);   // E18
        chk("t1_e18_a",      32'(stage_rst_a),   32'h8);
        chk("t1_e18_rdy_a",  32'(all_ready_a),   32'h0);
        steps(1);   // E19
        chk("t1_e19_a",      32'(stage_rst_a),   32'h0);
        chk("t1_e19_rdy_a",  32'(all_ready_a),   32'h1);
        chk("t2_e19_b",      32'(stage_rst_b),   32'hC);
        steps(1);   // E20: ack[1] raised, first sampled at E21
        ack_b = 4'b0010;
        steps(4);   // E24
        chk("t2_e24_b",      32'(stage_rst_b),   32'hC);
        steps(1);   // E25
        chk("t2_e25_b",      32'(stage_rst_b),   32'h8);
        steps(3);   // E28
        chk("t2_e28_rdy_b",  32'(all_ready_b),   32'h0);
        steps(1);   // E29
        chk("t2_e29_b",      32'(stage_rst_b),   32'h0);
        chk("t2_e29_rdy_b",  32'(all_ready_b),   32'h1);
        chk("t2_e29_flt_b",  32'(fault_b),       32'h0);

        // ---------------- T6: 1-cycle rst in RUN; T5a: ack high before entry ----------------
        rst = 1'b1;
        steps(1);
        chk("t6_stage_a",    32'(stage_rst_a),   32'hF);
        chk("t6_ready_a",    32'(all_ready_a),   32'h0);
        chk("t6_fault_a",    32'(fault_a),       32'h0);
        chk("t6_stage_b",    32'(stage_rst_b),   32'hF);
        chk("t6_ready_b",    32'(all_ready_b),   32'h0);
        rst = 1'b0;
        steps(6);   // F6
        chk("t6_f6_a",       32'(stage_rst_a),   32'hF);
        steps(1);   // F7
        chk("t6_f7_a",       32'(stage_rst_a),   32'hE);
        chk("t5_f7_b",       32'(stage_rst_b),   32'hE);
        steps(4);   // F11
        chk("t6_f11_a",      32'(stage_rst_a),   32'hC);
        chk("t5_f11_b",      32'(stage_rst_b),   32'hC);
        steps(1);   // F12
        chk("t5_f12_b",      32'(stage_rst_b),   32'hC);
        steps(3);   // F15
        chk("t6_f15_a",      32'(stage_rst_a),   32'h8);
        chk("t5_f15_b",      32'(stage_rst_b),   32'hC);
        steps(1);   // F16
        chk("t5_f16_b",      32'(stage_rst_b),   32'h8);
        steps(3);   // F19
        chk("t6_f19_a",      32'(stage_rst_a),   32'h0);
        chk("t6_f19_rdy_a",  32'(all_ready_a),   32'h1);
        steps(1);   // F20
        chk("t5_f20_b",      32'(stage_rst_b),   32'h0);
        chk("t5_f20_rdy_b",  32'(all_ready_b),   32'h1);

        // ---------------- T4: lock loss after 1100 ----------------
        ack_b = 4'b0000;
        rst   = 1'b1;
        steps(1);
        rst = 1'b0;
        steps(11);  // G11
        chk("t4_g11_a",      32'(stage_rst_a),   32'hC);
        clk_ok = 1'b0;
        steps(2);   // G13
        chk("t4_g13_a",      32'(stage_rst_a),   32'hC);
        steps(1);   // G14
        chk("t4_g14_a",      32'(stage_rst_a),   32'hF);
        chk("t4_g14_rdy_a",  32'(all_ready_a),   32'h0);
        chk("t4_g14_b",      32'(stage_rst_b),   32'hF);
        clk_ok = 1'b1;
        steps(6);   // G20
        chk("t4_g20_a",      32'(stage_rst_a),   32'hF);
        steps(1);   // G21
        chk("t4_g21_a",      32'(stage_rst_a),   32'hE);
        steps(4);   // G25
        chk("t4_g25_a",      32'(stage_rst_a),   32'hC);
        steps(8);   // G33
        chk("t4_g33_a",      32'(stage_rst_a),   32'h0);
        chk("t4_g33_rdy_a",  32'(all_ready_a),   32'h1);

        // ---------------- T3: ack timeout on stage 1 ----------------
        rst = 1'b1;
        steps(1);
        rst = 1'b0;
        steps(30);  // J30: last WAIT_ACK cycle
        chk("t3_j30_flt_b",  32'(fault_b),       32'h0);
        chk("t3_j30_b",      32'(stage_rst_b),   32'hC);
        steps(1);   // J31
        chk("t3_j31_flt_b",  32'(fault_b),       32'h1);
        chk("t3_j31_fst_b",  32'(fault_stage_b), 32'h1);
        chk("t3_j31_b",      32'(stage_rst_b),   32'hF);
        chk("t3_j31_rdy_b",  32'(all_ready_b),   32'h0);
        ack_b  = 4'b0010;
        clk_ok = 1'b0;
        steps(4);
        clk_ok = 1'b1;
        steps(4);
        chk("t3_hold_flt_b", 32'(fault_b),       32'h1);
        chk("t3_hold_fst_b", 32'(fault_stage_b), 32'h1);
        chk("t3_hold_b",     32'(stage_rst_b),   32'hF);
        chk("t3_hold_rdy_b", 32'(all_ready_b),   32'h0);
        rst = 1'b1;
        steps(1);
        chk("t3_clr_flt_b",  32'(fault_b),       32'h0);
        chk("t3_clr_fst_b",  32'(fault_stage_b), 32'h0);
        chk("t3_clr_b",      32'(stage_rst_b),   32'hF);

        // ---------------- T5b: ack arrives on the final timeout count ----------------
        rst   = 1'b0;
        ack_b = 4'b0000;
        steps(7);   // K7
        chk("t5_k7_b",       32'(stage_rst_b),   32'hE);
        steps(23);  // K30: cnt == 19 in the cycle that follows
        chk("t5_k30_b",      32'(stage_rst_b),   32'hC);
        chk("t5_k30_flt_b",  32'(fault_b),       32'h0);
        ack_b = 4'b0010;
        steps(1);   // K31
        chk("t5_k31_flt_b",  32'(fault_b),       32'h0);
        chk("t5_k31_b",      32'(stage_rst_b),   32'hC);
        steps(4);   // K35
        chk("t5_k35_b",      32'(stage_rst_b),   32'h8);
        steps(4);   // K39
        chk("t5_k39_b",      32'(stage_rst_b),   32'h0);
        chk("t5_k39_rdy_b",  32'(all_ready_b),   32'h1);
        chk("t5_k39_flt_b",  32'(fault_b),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
